// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced button level into press/release/click/double-click/long-press pulses.
// All timeouts are counted in prescaler ticks so only parameters change with clock rate.
module btn_event_decoder #(
    parameter int TICK_BITS    = 19,
    parameter int LONG_TICKS   = 100,
    parameter int DCLICK_TICKS = 30,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic press,
    output logic rel,
    output logic click,
    output logic dclick,
    output logic long,
    output logic held
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DOWN1 = 3'd1;
    localparam logic [2:0] ST_WAIT2 = 3'd2;
    localparam logic [2:0] ST_DOWN2 = 3'd3;
    localparam logic [2:0] ST_LONG  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 db_q;
    logic [TICK_BITS-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic press_q, press_d, rel_q, rel_d, click_q, click_d;
    logic dclick_q, dclick_d, long_q, long_d, held_q, held_d;
    logic rise, fall, tick, long_to, dclk_to, legal, counting;

    assign rise     = db & ~db_q;
    assign fall     = ~db & db_q;
    assign tick     = presc_q == '1;
    assign long_to  = tick && cnt_q == CNT_W'(LONG_TICKS - 1);
    assign dclk_to  = tick && cnt_q == CNT_W'(DCLICK_TICKS - 1);
    assign legal    = state_q <= ST_LONG;
    assign counting = state_q == ST_DOWN1 || state_q == ST_WAIT2 || state_q == ST_DOWN2;

    // Edges are tested before timeouts so a db edge always wins a same-cycle tick.
    always_comb begin
        presc_d  = presc_q + 1'b1;
        state_d  = state_q;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            ST_IDLE:  if (rise) state_d = ST_DOWN1;
            ST_DOWN1: begin
                if (fall) state_d = ST_WAIT2;
                else if (long_to) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) state_d = ST_DOWN2;
                else if (dclk_to) begin
                    state_d = ST_IDLE;
                    click_d = 1'b1;
                end
            end
            ST_DOWN2: begin
                if (fall) begin
                    state_d  = ST_IDLE;
                    dclick_d = 1'b1;
                end else if (long_to) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_LONG:  if (fall) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        press_d = rise & legal;
        rel_d   = fall & legal;
        held_d  = state_d == ST_LONG;
        cnt_d   = (state_d != state_q) ? '0 : (tick && counting) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            db_q     <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_q     <= db;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            click_q  <= click_d;
            dclick_q <= dclick_d;
            long_q   <= long_d;
            held_q   <= held_d;
        end
    end

    assign press  = press_q;
    assign rel    = rel_q;
    assign click  = click_q;
    assign dclick = dclick_q;
    assign long   = long_q;
    assign held   = held_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: scoreboard bench; scenarios push expected {cycle, event} pairs,
// a negedge monitor pops and compares them whenever the decoder emits a pulse.
module tb_btn_event_decoder;
    localparam logic [4:0] P = 5'b10000, R = 5'b01000, C = 5'b00100, D = 5'b00010, L = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] ev;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, db = 1'b0;
    logic press, rel, click, dclick, lng, held;
    int   tests = 0, fails = 0, cyc = 0;
    exp_t sb[$];

    btn_event_decoder #(.TICK_BITS(2), .LONG_TICKS(5), .DCLICK_TICKS(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .db(db), .press(press), .rel(rel),
        .click(click), .dclick(dclick), .long(lng), .held(held)
    );

    always #5 clk = ~clk;

    // Edge count since the last reset release; the prescaler restarts with it.
    always @(posedge clk or posedge reset) cyc <= reset ? 0 : cyc + 1;

    always @(negedge clk) begin
        logic [4:0] ev;
        exp_t       x;
        if (!reset) begin
            ev = {press, rel, click, dclick, lng};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                x = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL missed_event required=%b at cyc %0d, now cyc %0d", x.ev, x.cyc, cyc);
            end
            if (ev != 5'b0) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event got=%b at cyc %0d, required none", ev, cyc);
                end else begin
                    x = sb.pop_front();
                    if (x.cyc !== cyc || x.ev !== ev) begin
                        fails++;
                        $display("FAIL event got=%b@%0d required=%b@%0d", ev, cyc, x.ev, x.cyc);
                    end
                end
            end
        end
    end

    // k-th edge after e whose decision sees tick (edges n with n % 4 == 0).
    function automatic int tick_edge(int e, int k);
        int n = e;
        for (int i = 0; i < k; i++) begin
            n++;
            while (n % 4 != 0) n++;
        end
        return n;
    endfunction

    function automatic exp_t mk(int c, logic [4:0] ev);
        exp_t x;
        x.cyc = c;
        x.ev  = ev;
        return x;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_to(int n);
        while (cyc < n) step(1);
    endtask

    task automatic check_drained(string name);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drained pending=%0d required=0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if ({press, rel, click, dclick, lng, held} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs got=%b required=000000", {press, rel, click, dclick, lng, held});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(8);
        check_drained("reset_idle");
    endtask

    task automatic test_click;
        int c = cyc;
        db = 1'b1;
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(c + 7, R));
        sb.push_back(mk(tick_edge(c + 7, 3), C));
        step(6);
        db = 1'b0;
        step(20);
        check_drained("click");
    endtask

    task automatic test_dclick;
        int c = cyc;
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(c + 7, R));
        sb.push_back(mk(c + 11, P));
        sb.push_back(mk(c + 17, R | D));
        db = 1'b1;
        step(6);
        db = 1'b0;
        step(4);
        db = 1'b1;
        step(6);
        db = 1'b0;
        step(20);
        check_drained("dclick");
    endtask

    task automatic test_long;
        int c = cyc;
        int lt = tick_edge(c + 1, 5);
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(lt, L));
        sb.push_back(mk(c + 41, R));
        db = 1'b1;
        go_to(lt - 1);
        tests++;
        if (held !== 1'b0) begin fails++; $display("FAIL long_held_early got=%b required=0", held); end
        step(1);
        tests++;
        if (held !== 1'b1) begin fails++; $display("FAIL long_held_rise got=%b required=1", held); end
        go_to(c + 40);
        tests++;
        if (held !== 1'b1) begin fails++; $display("FAIL long_held_stay got=%b required=1", held); end
        db = 1'b0;
        step(1);
        tests++;
        if (held !== 1'b0 || rel !== 1'b1) begin
            fails++;
            $display("FAIL long_held_fall held=%b rel=%b required held=0 rel=1", held, rel);
        end
        step(20);
        check_drained("long");
    endtask

    task automatic test_collide_long;
        int c = cyc;
        int lt = tick_edge(c + 1, 5);
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(lt, R));
        sb.push_back(mk(tick_edge(lt, 3), C));
        db = 1'b1;
        go_to(lt - 1);
        db = 1'b0;
        step(1);
        tests++;
        if (held !== 1'b0) begin fails++; $display("FAIL collide_long_held got=%b required=0", held); end
        step(20);
        check_drained("collide_long");
    endtask

    task automatic test_collide_click;
        int c = cyc;
        int t = tick_edge(c + 7, 3);
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(c + 7, R));
        sb.push_back(mk(t, P));
        sb.push_back(mk(t + 4, R | D));
        db = 1'b1;
        step(6);
        db = 1'b0;
        go_to(t - 1);
        db = 1'b1;
        step(4);
        db = 1'b0;
        step(20);
        check_drained("collide_click");
    endtask

    task automatic test_reset_mid;
        int c = cyc;
        int lt = tick_edge(c + 1, 5);
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(lt, L));
        db = 1'b1;
        go_to(lt + 2);
        check_drained("pre_reset");
        tests++;
        if (held !== 1'b1) begin fails++; $display("FAIL reset_mid_held got=%b required=1", held); end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({press, rel, click, dclick, lng, held} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid_async got=%b required=000000", {press, rel, click, dclick, lng, held});
        end
        step(2);
        sb.push_back(mk(1, P));
        sb.push_back(mk(5, R));
        sb.push_back(mk(tick_edge(5, 3), C));
        reset = 1'b0;
        step(4);
        db = 1'b0;
        step(20);
        check_drained("reset_mid");
    endtask

    task automatic test_back_to_back;
        int c = cyc;
        sb.push_back(mk(c + 1, P));
        sb.push_back(mk(c + 4, R));
        sb.push_back(mk(c + 6, P));
        sb.push_back(mk(c + 9, R | D));
        sb.push_back(mk(c + 11, P));
        sb.push_back(mk(c + 14, R));
        sb.push_back(mk(tick_edge(c + 14, 3), C));
        for (int i = 0; i < 3; i++) begin
            db = 1'b1;
            step(3);
            db = 1'b0;
            step(2);
        end
        step(20);
        check_drained("back_to_back");
    endtask

    initial begin
        test_reset;
        test_click;
        test_dclick;
        test_long;
        test_collide_long;
        test_collide_click;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
